// File: rtl/spu_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : spu_sched_pkg                                                 |
// | Purpose  : Shared definitions for the special_pu command path: packed    |
// |            command layout (field offsets and widths), scheduler state    |
// |            encoding and pack/unpack helpers used by the decoder, the     |
// |            scheduler and the special_pu wrapper.                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package spu_sched_pkg;

   // Address width of the default build (gbuf address / matrix dimensions).
   localparam int SPU_AW = 12;

   // Narrow field widths.
   localparam int OP_W  = 1;
   localparam int SH0_W = 4;
   localparam int SH1_W = 4;
   localparam int SH2_W = 5;
   localparam int LNM_W = 7;
   localparam int LNE_W = 5;

   // Bit offsets, LSB first (om_align occupies the least significant bits).
   localparam int OFS_OM_ALIGN = 0;
   localparam int OFS_IM_ALIGN = OFS_OM_ALIGN + SPU_AW;
   localparam int OFS_OM_BASE  = OFS_IM_ALIGN + SPU_AW;
   localparam int OFS_IM_BASE  = OFS_OM_BASE  + SPU_AW;
   localparam int OFS_LN_DIV_E = OFS_IM_BASE  + SPU_AW;
   localparam int OFS_LN_DIV_M = OFS_LN_DIV_E + LNE_W;
   localparam int OFS_SHIFT2   = OFS_LN_DIV_M + LNM_W;
   localparam int OFS_SHIFT1   = OFS_SHIFT2   + SH2_W;
   localparam int OFS_SHIFT0   = OFS_SHIFT1   + SH1_W;
   localparam int OFS_MATRIX_X = OFS_SHIFT0   + SH0_W;
   localparam int OFS_MATRIX_Y = OFS_MATRIX_X + SPU_AW;
   localparam int OFS_OP       = OFS_MATRIX_Y + SPU_AW;
   localparam int CMD_W        = OFS_OP + OP_W;   // 98 at SPU_AW = 12

   // Field order matches the offsets above, MSB first.
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [SPU_AW-1:0] matrix_y;
      logic [SPU_AW-1:0] matrix_x;
      logic [SH0_W-1:0]  shift0;
      logic [SH1_W-1:0]  shift1;
      logic [SH2_W-1:0]  shift2;
      logic [LNM_W-1:0]  ln_div_m;
      logic [LNE_W-1:0]  ln_div_e;
      logic [SPU_AW-1:0] im_base;
      logic [SPU_AW-1:0] om_base;
      logic [SPU_AW-1:0] im_align;
      logic [SPU_AW-1:0] om_align;
   } spu_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CFG   = 2'd1,
      ST_START = 2'd2,
      ST_BUSY  = 2'd3
   } sched_state_t;

   function automatic logic [CMD_W-1:0] pack_cmd(input spu_cmd_t c);
      return c;
   endfunction

   function automatic spu_cmd_t unpack_cmd(input logic [CMD_W-1:0] v);
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spu_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spu_cmd_fifo                                                  |
// | Purpose  : Synchronous command FIFO, DEPTH x WIDTH. Pointers carry one   |
// |            extra wrap bit to tell full from empty. Head entry is         |
// |            presented combinationally on rd_data.                         |
// | Ports    : core_clk, rst_n (async, active-low)                           |
// |            push/wr_data   write request (ignored when full or flushing)  |
// |            pop            read request (ignored when empty or flushing)  |
// |            flush          empties the FIFO at the next edge              |
// |            rd_data        head entry; full/empty status flags            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module spu_cmd_fifo
   import spu_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 98
) (
   input  logic             core_clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   // A flush discards everything, including a push or pop in the same cycle.
   assign wr_en = push && !full  && !flush;
   assign rd_en = pop  && !empty && !flush;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign rd_data = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: contents are only visible through valid pointers.
   always_ff @(posedge core_clk) begin
      if (wr_en) mem[wr_ptr[PW-1:0]] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/spu_cmd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spu_cmd_sched                                                 |
// | Purpose  : Command scheduler for special_pu. Queues commands in a FIFO   |
// |            and sequences special_pu: one-cycle spu_config_en, one-cycle  |
// |            spu_start, then waits for spu_end before the next command.    |
// |            The config bus spu_cmd is held stable for each command.       |
// | Option   : SPU_SCHED_TIMEOUT_EN - BUSY watchdog of TIMEOUT_CYC cycles;    |
// |            on expiry timeout_err is set (sticky) and the queue resumes.  |
// | Ports    : core_clk, rst_n (async, active-low)                           |
// |            cmd_valid/cmd_ready/cmd_data  command push interface          |
// |            flush                         drop queued, unissued commands  |
// |            spu_config_en/spu_start/spu_end/spu_cmd  special_pu link      |
// |            sched_busy, done_pulse, done_cnt, timeout_err  status         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module spu_cmd_sched
   import spu_sched_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 65535,
   parameter int CMD_W       = 1 + 4*ADDR_WIDTH + 4 + 4 + 5 + 7 + 5 + 2*ADDR_WIDTH
) (
   input  logic             core_clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CMD_W-1:0] cmd_data,
   input  logic             flush,
   output logic             spu_config_en,
   output logic             spu_start,
   input  logic             spu_end,
   output logic [CMD_W-1:0] spu_cmd,
   output logic             sched_busy,
   output logic             done_pulse,
   output logic [15:0]      done_cnt,
   output logic             timeout_err
);

   sched_state_t     state;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic [CMD_W-1:0] head;

   // Popping only from IDLE gives the one-cycle gap between commands; a
   // flush in the same cycle wins so a dropped command is never issued.
   assign pop = (state == ST_IDLE) && !fifo_empty && !flush;

   spu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .core_clk (core_clk),
      .rst_n    (rst_n),
      .push     (cmd_valid),
      .wr_data  (cmd_data),
      .pop      (pop),
      .flush    (flush),
      .rd_data  (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign cmd_ready  = !fifo_full;
   assign sched_busy = (state != ST_IDLE) || !fifo_empty;

`ifdef SPU_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            tmo_flag;
   assign timeout_err = tmo_flag;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         spu_config_en <= 1'b0;
         spu_start     <= 1'b0;
         spu_cmd       <= '0;
         done_pulse    <= 1'b0;
         done_cnt      <= 16'd0;
`ifdef SPU_SCHED_TIMEOUT_EN
         wd_cnt        <= '0;
         tmo_flag      <= 1'b0;
`endif
      end else begin
         // Strobes default low so each one lasts exactly one cycle.
         spu_config_en <= 1'b0;
         spu_start     <= 1'b0;
         done_pulse    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  spu_cmd       <= head;
                  spu_config_en <= 1'b1;
                  state         <= ST_CFG;
               end
            end
            ST_CFG: begin
               spu_start <= 1'b1;
               state     <= ST_START;
            end
            ST_START: begin
`ifdef SPU_SCHED_TIMEOUT_EN
               wd_cnt <= '0;
`endif
               state  <= ST_BUSY;
            end
            ST_BUSY: begin
               // A real completion takes priority over a coincident timeout.
               if (spu_end) begin
                  done_pulse <= 1'b1;
                  done_cnt   <= done_cnt + 16'd1;
                  state      <= ST_IDLE;
               end
`ifdef SPU_SCHED_TIMEOUT_EN
               else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                  tmo_flag <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spu_cmd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spu_cmd_sched                                              |
// | Purpose  : Self-checking bench for spu_cmd_sched. A transaction-level    |
// |            model (queue of pending commands plus the timeline of the     |
// |            command in flight) predicts every output each cycle.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_spu_cmd_sched;
   import spu_sched_pkg::*;

   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic             core_clk = 1'b0;
   logic             rst_n    = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [CMD_W-1:0] cmd_data = '0;
   logic             flush = 1'b0;
   logic             spu_config_en;
   logic             spu_start;
   logic             spu_end = 1'b0;
   logic [CMD_W-1:0] spu_cmd;
   logic             sched_busy;
   logic             done_pulse;
   logic [15:0]      done_cnt;
   logic             timeout_err;

   always #5 core_clk = ~core_clk;

   spu_cmd_sched #(
      .ADDR_WIDTH  (12),
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .core_clk      (core_clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_data      (cmd_data),
      .flush         (flush),
      .spu_config_en (spu_config_en),
      .spu_start     (spu_start),
      .spu_end       (spu_end),
      .spu_cmd       (spu_cmd),
      .sched_busy    (sched_busy),
      .done_pulse    (done_pulse),
      .done_cnt      (done_cnt),
      .timeout_err   (timeout_err)
   );

   // ---------------- reference model ----------------
   // Each queued entry remembers how long special_pu should take once issued
   // (dly extra BUSY cycles before spu_end; negative means never ends).
   typedef struct {
      logic [CMD_W-1:0] data;
      int               dly;
   } ent_t;

   ent_t             q[$];
   int               k;          // cycle index
   bit               have_cur;   // a command is in CFG/START/BUSY
   int               cur_cfg;    // cycle its config strobe is high
   int               cur_end;    // cycle spu_end is driven
   bit               cur_never;
   logic [CMD_W-1:0] cur_data;
   logic [15:0]      m_cnt;
   int               last_done;
   bit               m_tout;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
      end
   endtask

   task automatic model_reset();
      q.delete();
      have_cur  = 0;
      cur_never = 0;
      cur_data  = '0;
      m_cnt     = 16'd0;
      last_done = -1;
      m_tout    = 0;
   endtask

   task automatic check_outputs();
      chk("cmd_ready",  cmd_ready,     q.size() < DEPTH);
      chk("sched_busy", sched_busy,    have_cur || (q.size() > 0));
      chk("config_en",  spu_config_en, have_cur && (cur_cfg == k));
      chk("start",      spu_start,     have_cur && (cur_cfg + 1 == k));
      chk("done_pulse", done_pulse,    last_done == k);
      chk("done_cnt",   done_cnt,      m_cnt);
      chk("spu_cmd",    spu_cmd,       cur_data);
      chk("timeout",    timeout_err,   m_tout);
   endtask

   // Effect of the clock edge that closes cycle k.
   task automatic model_edge(input bit v, input logic [CMD_W-1:0] d, input bit fl, input int dly);
      int   old_size;
      bit   was_idle;
      ent_t e;
      old_size = q.size();
      was_idle = !have_cur;
      if (have_cur) begin
         if (!cur_never && k == cur_end) begin
            m_cnt     = m_cnt + 16'd1;
            last_done = k + 1;
            have_cur  = 0;
         end
`ifdef SPU_SCHED_TIMEOUT_EN
         else if (k == cur_cfg + 1 + TMO) begin
            m_tout   = 1;
            have_cur = 0;
         end
`endif
      end
      if (was_idle && old_size > 0 && !fl) begin
         e         = q.pop_front();
         cur_data  = e.data;
         have_cur  = 1;
         cur_cfg   = k + 1;
         cur_never = (e.dly < 0);
         cur_end   = cur_cfg + 2 + e.dly;
      end
      if (fl) begin
         q.delete();
      end else if (v && old_size < DEPTH) begin
         e.data = d;
         e.dly  = dly;
         q.push_back(e);
      end
   endtask

   // One cycle of stimulus; entered and left 1 time unit after a rising edge.
   task automatic step(input bit v, input logic [CMD_W-1:0] d, input bit fl,
                       input bit spur, input int dly);
      cmd_valid = v;
      cmd_data  = d;
      flush     = fl;
      spu_end   = (have_cur && !cur_never && k == cur_end) ||
                  (spur && !(have_cur && k >= cur_cfg + 2));
      @(negedge core_clk);
      check_outputs();
      @(posedge core_clk);
      model_edge(v, d, fl, dly);
      k++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      flush     = 1'b0;
      spu_end   = 1'b0;
      model_reset();
      @(negedge core_clk);
      check_outputs();
      @(posedge core_clk);
      #1;
      @(negedge core_clk);
      check_outputs();
      @(posedge core_clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [CMD_W-1:0] rand_cmd();
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      return r[CMD_W-1:0];
   endfunction

   initial begin
      spu_cmd_t c;
      k = 0;
      do_reset();

      // Single command: y=5, x=64, shifts 7/3/5; spu_end 10 cycles after start.
      c          = '0;
      c.matrix_y = 12'd5;
      c.matrix_x = 12'd64;
      c.shift0   = 4'd7;
      c.shift1   = 4'd3;
      c.shift2   = 5'd5;
      step(1, pack_cmd(c), 0, 0, 9);
      idle(3);
      chk("field_y",      spu_cmd[OFS_MATRIX_Y +: SPU_AW], 12'd5);
      chk("field_x",      spu_cmd[OFS_MATRIX_X +: SPU_AW], 12'd64);
      chk("field_shift0", spu_cmd[OFS_SHIFT0 +: SH0_W],    4'd7);
      idle(14);

      // Fill the queue behind a long command; the fifth push is dropped.
      step(1, rand_cmd(), 0, 0, 25);
      idle(2);
      for (int i = 0; i < 5; i++) step(1, rand_cmd(), 0, 0, i % 3);
      idle(80);

      // Spurious spu_end outside BUSY must be ignored.
      step(1, rand_cmd(), 0, 1, 3);
      for (int i = 0; i < 10; i++) step(0, '0, 0, 1, 0);

      // Queue three, flush while the first is BUSY.
      step(1, rand_cmd(), 0, 0, 8);
      step(1, rand_cmd(), 0, 0, 2);
      step(1, rand_cmd(), 0, 0, 2);
      idle(3);
      step(0, '0, 1, 0, 0);
      idle(20);

      // Reset in the middle of BUSY.
      step(1, rand_cmd(), 0, 0, 20);
      step(1, rand_cmd(), 0, 0, 2);
      idle(6);
      do_reset();
      idle(4);

`ifdef SPU_SCHED_TIMEOUT_EN
      // No spu_end: watchdog expires, the next command still issues.
      step(1, rand_cmd(), 0, 0, -1);
      step(1, rand_cmd(), 0, 0, 2);
      idle(40);
`endif

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom() % 3) != 0, rand_cmd(), ($urandom() % 40) == 0,
              ($urandom() % 6) == 0, int'($urandom() % 8));
      end
      idle(60);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
